apb_slave_regs: RTL and testbench

- Parametrised APB3/APB4 completer that sits on the shared APB bus behind the existing APB interface signals (pclk, presetn, paddr, pwdata, prdata, pwrite, psel, penable).
- Extends that signal set with pstrb, pready and pslverr. Adds a configurable wait-state count, address and alignment error reporting, and read-only registers fed by hardware.
- Exposes a bank of NUM_REGS control/status registers to downstream logic, with per-register write pulses.

---
 rtl/apb_slave_regs_if.sv | 26 ++
 rtl/apb_slave_regs.sv | 110 +++++++++++
 tb/tb_apb_slave_regs.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regs_if.sv
// APB3/APB4 bus bundle between a requester and the apb_slave_regs completer.
// The requester drives address, control and write data; the completer answers.
interface apb_slave_regs_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   paddr;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pready;
   logic                    pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_slave_regs.sv
// APB completer exposing NUM_REGS word registers with byte strobes, wait states,
// address/read-only error reporting and a one-cycle write pulse per register.
module apb_slave_regs #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REGS    = 16,
   parameter int                    WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic                           pclk,
   input  logic                           presetn,
   apb_slave_regs_if.slave                apb,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            wr_pulse
);
   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(BYTES);
   localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK   = ADDR_WIDTH'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state;
   logic [3:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [IDX_W-1:0]      idx;
   logic                  err_addr;
   logic                  err_ro;
   logic                  acc_done;
   logic                  no_setup;
   logic                  commit;
   logic [NUM_REGS-1:0]   wr_sel;
   logic [DATA_WIDTH-1:0] reg_words [NUM_REGS];
   logic                  unused_reg_in;

   assign word_addr = apb.paddr >> ADDR_LSB;
   assign idx       = word_addr[IDX_W-1:0];
   assign err_addr  = (word_addr >= NUM_REGS_A) || (|(apb.paddr & LOW_MASK));
   assign err_ro    = apb.pwrite && !err_addr && RO_MASK[idx];

   // A normal completion, or a bare access phase seen in IDLE (missing setup).
   assign acc_done = (state == ACCESS) && apb.psel && apb.penable && (wait_cnt == 4'd0);
   assign no_setup = (state == IDLE) && apb.psel && apb.penable;
   assign commit   = acc_done && apb.pwrite && !err_addr && !err_ro;

   assign apb.pready  = presetn && (acc_done || no_setup);
   assign apb.pslverr = apb.pready && (no_setup || err_addr || err_ro);
   assign apb.prdata  = (presetn && acc_done && !apb.pwrite && !err_addr) ? reg_words[idx] : '0;

   always_comb begin
      wr_sel = '0;
      if (commit) wr_sel[idx] = 1'b1;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         wr_pulse <= '0;
      end else begin
         wr_pulse <= wr_sel;
         case (state)
            IDLE: begin
               if (apb.psel && !apb.penable) begin
                  state    <= ACCESS;
                  wait_cnt <= 4'(WAIT_STATES);
               end
            end
            ACCESS: begin
               // Dropping psel before completion abandons the transfer.
               if (!apb.psel) begin
                  state <= IDLE;
               end else if (!apb.penable) begin
                  wait_cnt <= 4'(WAIT_STATES);
               end else if (wait_cnt == 4'd0) begin
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (RO_MASK[i]) begin : g_ro
         assign reg_words[i] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_rw
         logic [DATA_WIDTH-1:0] value;
         always_ff @(posedge pclk or negedge presetn) begin
            if (!presetn) begin
               value <= RESET_VAL;
            end else if (wr_sel[i]) begin
               for (int b = 0; b < BYTES; b++) begin
                  if (apb.pstrb[b]) value[b*8 +: 8] <= apb.pwdata[b*8 +: 8];
               end
            end
         end
         assign reg_words[i] = value;
      end
      assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = reg_words[i];
   end

   // Slices of writable slots are intentionally ignored.
   assign unused_reg_in = ^reg_in;
endmodule

// File: tb/tb_apb_slave_regs.sv
// Randomised bench for apb_slave_regs: two instances (0 and 3 wait states) checked
// against an array-based register model with directed protocol corner cases.
module tb_apb_slave_regs;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 16;
   localparam logic [NR-1:0] RO0 = 16'h0002;
   localparam logic [NR-1:0] RO3 = 16'h8002;
   localparam logic [DW-1:0] RST = 32'hC0DE_0000;

   logic             pclk;
   logic             presetn;
   logic [AW-1:0]    paddr;
   logic [1:0]       psel;
   logic             penable;
   logic             pwrite;
   logic [DW-1:0]    pwdata;
   logic [DW/8-1:0]  pstrb;
   logic [NR*DW-1:0] reg_in;
   logic [NR*DW-1:0] reg_out0;
   logic [NR*DW-1:0] reg_out3;
   logic [NR-1:0]    wr_pulse0;
   logic [NR-1:0]    wr_pulse3;

   logic [DW-1:0] model [2][NR];
   logic [NR-1:0] pendPulse [2];
   int numChecks = 0;
   int numBad = 0;

   apb_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
   apb_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

   assign bus0.paddr   = paddr;
   assign bus0.psel    = psel[0];
   assign bus0.penable = penable;
   assign bus0.pwrite  = pwrite;
   assign bus0.pwdata  = pwdata;
   assign bus0.pstrb   = pstrb;
   assign bus3.paddr   = paddr;
   assign bus3.psel    = psel[1];
   assign bus3.penable = penable;
   assign bus3.pwrite  = pwrite;
   assign bus3.pwdata  = pwdata;
   assign bus3.pstrb   = pstrb;

   apb_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0),
                    .RO_MASK(RO0), .RESET_VAL(RST)) dut0 (
      .pclk(pclk), .presetn(presetn), .apb(bus0.slave),
      .reg_in(reg_in), .reg_out(reg_out0), .wr_pulse(wr_pulse0));

   apb_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(3),
                    .RO_MASK(RO3), .RESET_VAL(RST)) dut3 (
      .pclk(pclk), .presetn(presetn), .apb(bus3.slave),
      .reg_in(reg_in), .reg_out(reg_out3), .wr_pulse(wr_pulse3));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [DW-1:0] refRead(input int d, input int i);
      logic [NR-1:0] ro;
      ro = (d == 1) ? RO3 : RO0;
      return ro[i] ? reg_in[i*DW +: DW] : model[d][i];
   endfunction

   function automatic logic obsReady(input int d);
      return (d == 1) ? bus3.pready : bus0.pready;
   endfunction

   function automatic logic obsSlverr(input int d);
      return (d == 1) ? bus3.pslverr : bus0.pslverr;
   endfunction

   function automatic logic [DW-1:0] obsRdata(input int d);
      return (d == 1) ? bus3.prdata : bus0.prdata;
   endfunction

   function automatic logic [NR*DW-1:0] randomRegIn();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = $urandom;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      numChecks++;
      if (obs !== exp) begin
         numBad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkPulses(input string tag);
      checkOutput({tag, "_pulse0"}, 64'(wr_pulse0), 64'(pendPulse[0]));
      checkOutput({tag, "_pulse3"}, 64'(wr_pulse3), 64'(pendPulse[1]));
      pendPulse[0] = '0;
      pendPulse[1] = '0;
   endtask

   task automatic checkRegs();
      for (int i = 0; i < NR; i++) begin
         checkOutput("regout0", 64'(reg_out0[i*DW +: DW]), 64'(refRead(0, i)));
         checkOutput("regout3", 64'(reg_out3[i*DW +: DW]), 64'(refRead(1, i)));
      end
   endtask

   task automatic idleCycle();
      @(posedge pclk); #1;
      psel    = '0;
      penable = 1'b0;
      @(negedge pclk);
      checkPulses("idle");
      checkRegs();
   endtask

   // One complete transfer on instance d; expected latency is 2 + wait states.
   task automatic applyStimulus(input int d, input logic [AW-1:0] addr, input logic wr,
                                input logic [DW-1:0] data, input logic [3:0] strb,
                                input bit b2b, input bit newRegIn);
      int ws = (d == 1) ? 3 : 0;
      int idx = int'(addr >> 2);
      bit inRange = (addr >> 2) < NR;
      logic [NR-1:0] ro = (d == 1) ? RO3 : RO0;
      logic [NR-1:0] one = 1;
      bit err;
      @(posedge pclk); #1;
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      pstrb   = strb;
      @(negedge pclk);
      checkPulses("setup");
      checkOutput("setup_ready", 64'(obsReady(d)), 64'(0));
      checkOutput("setup_rdata", 64'(obsRdata(d)), 64'(0));
      for (int k = 0; k <= ws; k++) begin
         @(posedge pclk); #1;
         penable = 1'b1;
         if (newRegIn && k == ws) reg_in = randomRegIn();
         @(negedge pclk);
         if (k < ws) begin
            checkOutput("wait_ready", 64'(obsReady(d)), 64'(0));
            checkOutput("wait_slverr", 64'(obsSlverr(d)), 64'(0));
            checkOutput("wait_rdata", 64'(obsRdata(d)), 64'(0));
            checkOutput("wait_pulse", 64'((d == 1) ? wr_pulse3 : wr_pulse0), 64'(0));
         end
      end
      err = !inRange || (addr[1:0] != 2'b00) || (wr && ro[idx]);
      checkOutput("done_ready", 64'(obsReady(d)), 64'(1));
      checkOutput("done_slverr", 64'(obsSlverr(d)), 64'(err));
      if (wr || err) checkOutput("done_rdata", 64'(obsRdata(d)), 64'(0));
      else           checkOutput("done_rdata", 64'(obsRdata(d)), 64'(refRead(d, idx)));
      if (wr && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[d][idx][b*8 +: 8] = data[b*8 +: 8];
         end
         pendPulse[d] = one << idx;
      end
      if (!b2b) idleCycle();
   endtask

   // Access phase with no preceding setup: immediate error completion.
   task automatic missingSetup(input int d, input logic [AW-1:0] addr);
      @(posedge pclk); #1;
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = addr;
      pwdata  = $urandom;
      pstrb   = 4'hF;
      @(negedge pclk);
      checkPulses("nosetup");
      checkOutput("nosetup_ready", 64'(obsReady(d)), 64'(1));
      checkOutput("nosetup_slverr", 64'(obsSlverr(d)), 64'(1));
      checkOutput("nosetup_rdata", 64'(obsRdata(d)), 64'(0));
      idleCycle();
   endtask

   task automatic abortWrite(input logic [AW-1:0] addr);
      @(posedge pclk); #1;
      psel    = 2'b10;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = addr;
      pwdata  = 32'h9999_AAAA;
      pstrb   = 4'hF;
      @(negedge pclk);
      checkPulses("abort_setup");
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      checkOutput("abort_wait1", 64'(obsReady(1)), 64'(0));
      @(posedge pclk); #1;
      psel = '0;
      @(negedge pclk);
      checkOutput("abort_wait2", 64'(obsReady(1)), 64'(0));
      // An idle FSM answers a bare access phase at once.
      missingSetup(1, addr);
   endtask

   task automatic resetMidAccess();
      @(posedge pclk); #1;
      psel    = 2'b10;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h08;
      pwdata  = 32'h1357_9BDF;
      pstrb   = 4'hF;
      @(negedge pclk);
      checkPulses("rst_setup");
      @(posedge pclk); #1;
      penable = 1'b1;
      #2;
      presetn = 1'b0;
      @(negedge pclk);
      checkOutput("rst_ready", 64'(obsReady(1)), 64'(0));
      checkOutput("rst_slverr", 64'(obsSlverr(1)), 64'(0));
      checkOutput("rst_rdata", 64'(obsRdata(1)), 64'(0));
      for (int d = 0; d < 2; d++) for (int i = 0; i < NR; i++) model[d][i] = RST;
      checkPulses("rst");
      checkRegs();
      #1;
      presetn = 1'b1;
      psel    = '0;
      penable = 1'b0;
      idleCycle();
   endtask

   initial begin
      int d;
      int r;
      int i;
      logic [AW-1:0] a;
      presetn = 1'b1;
      psel    = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      reg_in  = randomRegIn();
      reg_in[1*DW +: DW] = 32'h5A5A_0001;
      pendPulse[0] = '0;
      pendPulse[1] = '0;
      for (int dd = 0; dd < 2; dd++) for (int k = 0; k < NR; k++) model[dd][k] = RST;

      #1 presetn = 1'b0;
      @(posedge pclk); #1;
      psel    = 2'b11;
      penable = 1'b1;
      @(negedge pclk);
      checkOutput("reset_ready0", 64'(obsReady(0)), 64'(0));
      checkOutput("reset_ready3", 64'(obsReady(1)), 64'(0));
      checkOutput("reset_slverr0", 64'(obsSlverr(0)), 64'(0));
      checkOutput("reset_rdata0", 64'(obsRdata(0)), 64'(0));
      checkPulses("reset");
      checkRegs();
      #1;
      presetn = 1'b1;
      psel    = '0;
      penable = 1'b0;
      idleCycle();

      applyStimulus(0, 32'h08, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
      checkOutput("t1_regout", 64'(reg_out0[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
      applyStimulus(0, 32'h08, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);

      applyStimulus(0, 32'h00, 1'b1, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
      applyStimulus(0, 32'h00, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0);
      applyStimulus(0, 32'h00, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("t2_regout", 64'(reg_out0[DW-1:0]), 64'h0000_0000_11BB_33DD);

      applyStimulus(1, 32'h04, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(1, 32'h08, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

      applyStimulus(0, 32'h04, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
      applyStimulus(0, 32'h04, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
      checkOutput("t4_regout", 64'(reg_out0[DW +: DW]), 64'h0000_0000_5A5A_0001);

      applyStimulus(0, 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
      applyStimulus(0, 32'h02, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
      applyStimulus(0, 32'h40, 1'b1, 32'h7777_7777, 4'hF, 1'b0, 1'b0);

      applyStimulus(0, 32'h0C, 1'b1, 32'h1234_5678, 4'h0, 1'b0, 1'b0);

      applyStimulus(1, 32'h10, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
      applyStimulus(1, 32'h10, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      applyStimulus(0, 32'h14, 1'b1, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0);

      missingSetup(0, 32'h0C);
      abortWrite(32'h18);

      resetMidAccess();
      applyStimulus(1, 32'h08, 1'b1, 32'h0F0F_0F0F, 4'hF, 1'b0, 1'b0);
      applyStimulus(1, 32'h08, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         d = $urandom_range(0, 1);
         r = $urandom_range(0, 11);
         i = $urandom_range(0, NR - 1);
         if (r == 0)      a = 32'($urandom_range(16, 63)) << 2;
         else if (r == 1) a = (32'(i) << 2) | 32'($urandom_range(1, 3));
         else if (r == 2) a = $urandom;
         else             a = 32'(i) << 2;
         applyStimulus(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
      idleCycle();

      $display("test done: total=%0d bad=%0d", numChecks, numBad);
      $finish;
   end
endmodule
